ltl_monitor_sequencer: RTL
==========================

Name: ltl_monitor_sequencer

Overview:
- Sequencer that feeds one LTL automata cluster (Automata_ltl* block: `clk`, `run`, `reset`, 8-bit `symbols`, N report outputs) from a buffered trace-event stream.
- Frames each trace with an automaton reset pulse so the automaton's start-of-data cycle coincides with the first symbol.
- Gates `run` on symbol availability.
- Accumulates per-trace report results and hands them off over a valid/ready result port.

Parameters:
- FIFO_DEPTH, 8, symbol FIFO entries; power of 2, ≥2.
- NUM_REPORTS, 4, width of automaton report vector.
- CNT_W, 16, symbol counter and index width.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- s_valid  in  1  input symbol valid.
- s_ready  out  1  FIFO not full.
- s_symbol  in  8  trace symbol.
- s_last  in  1  marks final symbol of a trace.
- abort  in  1  single-cycle request to discard the current trace.
- auto_reset  out  1  reset to automaton.
- auto_run  out  1  run to automaton.
- auto_symbols  out  8  symbol to automaton.
- auto_report  in  NUM_REPORTS  automaton report outputs, registered inside the automaton.
- res_valid  out  1  result available.
- res_ready  in  1  result accepted.
- res_reports  out  NUM_REPORTS  sticky OR of reports over the trace.
- res_count  out  CNT_W  symbols consumed in the trace.
- res_first_idx  out  CNT_W  0-based index of the first symbol producing any report; all-ones if none.
- busy  out  1  state ≠ IDLE.

Behaviour:
- Reset values:
  - s_ready=1 (FIFO empty).
  - auto_reset=1.
  - auto_run=0, auto_symbols=0.
  - res_valid=0, res_reports=0, res_count=0, res_first_idx=all-ones.
  - busy=0.
  - State IDLE.
- FIFO push/pop:
  - Push on s_valid&s_ready, storing {s_last, s_symbol}.
  - Pop only in STREAM when auto_run=1.
  - Simultaneous push and pop when full is not allowed, since s_ready=0 when full.
  - Push and pop in the same cycle otherwise keep occupancy unchanged.
- State IDLE:
  - auto_reset=1.
  - Leave when FIFO is non-empty and res_valid=0; go to ARM and clear the accumulators.
- State ARM (exactly 1 cycle):
  - auto_reset=1, then STREAM.
  - Guarantees the head symbol is presented in the first cycle after reset deasserts (the automaton's start-of-data cycle).
- State STREAM:
  - auto_reset=0.
  - auto_run = FIFO non-empty; auto_symbols = FIFO head (combinational from the registered FIFO); one symbol per cycle.
  - FIFO empty → auto_run=0 stall; the automaton holds state; there is no timeout.
  - Popping an entry with last=1 → DRAIN.
- State DRAIN (1 cycle):
  - auto_run=0.
  - Exists to collect the report of the last symbol, then DONE.
- Report alignment:
  - auto_report in cycle t belongs to the symbol run in cycle t-1.
  - Keep a 1-stage pipeline of {run_d, idx_d}.
  - When run_d=1:
    - res_reports |= auto_report.
    - If auto_report≠0 and res_first_idx is all-ones, set res_first_idx=idx_d.
- Counting:
  - res_count increments per popped symbol and saturates at 2^CNT_W-1.
  - idx_d uses the pre-increment count.
- State DONE:
  - res_valid=1; outputs stable until res_valid&res_ready, then IDLE.
  - Input pushes still accepted, so the next trace buffers while the result waits.
- abort:
  - In ARM, STREAM or DRAIN: FIFO flushed, including a same-cycle push (which is dropped).
  - Accumulators cleared; no result produced; next state IDLE.
  - In IDLE or DONE: abort is ignored.
- Reset mid-trace: immediate return to reset values; FIFO contents lost.
- Back-to-back traces: after the DONE handshake there are at least 2 cycles (IDLE, ARM) with auto_reset=1 before the next trace's first run.

Test Plan:
1. Trace {0x10,0x50,0x90(last)}, streamed continuously, report model asserts bit1 for symbol 0x50:
   - Expected: first auto_run the cycle after auto_reset falls.
   - Expected: res_reports=4'b0010, res_count=3, res_first_idx=1.
2. Same trace with s_valid gaps of 2 cycles between symbols:
   - Expected: auto_run low during gaps; results identical to scenario 1.
3. 12-symbol trace with FIFO_DEPTH=8 and res_ready held 0 on a prior result:
   - Expected: s_ready falls after 8 pushes.
   - Expected: no symbol is lost after the handshake; res_count=12.
4. Report only on the last symbol (index 4 of 5):
   - Expected: captured via DRAIN; res_first_idx=4.
   - No report at all: res_first_idx=16'hFFFF, res_reports=0.
5. abort after 2 of 5 symbols:
   - Expected: FIFO flushed, no res_valid pulse, busy=0 within 1 cycle.
   - Expected: the next trace starts with auto_reset high for ≥2 cycles.
6. reset asserted mid-STREAM with 3 entries buffered:
   - Expected: next cycle s_ready=1, auto_run=0, res_valid=0, auto_reset=1.

Source files
------------

// File: rtl/ltl_monitor_sequencer.sv
// Feeds one LTL automata cluster from a buffered trace-event stream: frames each trace
// with an automaton reset, gates run on symbol availability and reports per-trace results.
module ltl_monitor_sequencer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int NUM_REPORTS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [7:0]             s_symbol,
  input  logic                   s_last,
  input  logic                   abort,
  output logic                   auto_reset,
  output logic                   auto_run,
  output logic [7:0]             auto_symbols,
  input  logic [NUM_REPORTS-1:0] auto_report,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [NUM_REPORTS-1:0] res_reports,
  output logic [CNT_W-1:0]       res_count,
  output logic [CNT_W-1:0]       res_first_idx,
  output logic                   busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_STREAM, ST_DRAIN, ST_DONE} state_t;

  state_t                 r_state;
  logic [8:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_fill;
  logic                   r_auto_reset;
  logic                   r_res_valid;
  logic                   r_busy;
  logic                   r_run_d;
  logic [CNT_W-1:0]       r_idx_d;
  logic [CNT_W-1:0]       r_res_count;
  logic [CNT_W-1:0]       r_res_first_idx;
  logic [NUM_REPORTS-1:0] r_res_reports;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_flush;
  logic [8:0]             w_head;

  assign w_empty = (r_fill == '0);
  assign w_full  = (r_fill == (AW + 1)'(FIFO_DEPTH));
  assign w_head  = r_mem[r_rd_ptr];
  assign w_flush = abort && (r_state inside {ST_ARM, ST_STREAM, ST_DRAIN});
  assign w_push  = s_valid && !w_full;
  assign w_pop   = (r_state == ST_STREAM) && !w_empty;

  assign s_ready       = !w_full;
  assign auto_run      = w_pop;
  assign auto_symbols  = w_pop ? w_head[7:0] : 8'h00;
  assign auto_reset    = r_auto_reset;
  assign res_valid     = r_res_valid;
  assign res_reports   = r_res_reports;
  assign res_count     = r_res_count;
  assign res_first_idx = r_res_first_idx;
  assign busy          = r_busy;

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_last, s_symbol};
  end

  // A flush wins over a same-cycle push, so that push is dropped.
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_auto_reset    <= 1'b1;
      r_res_valid     <= 1'b0;
      r_busy          <= 1'b0;
      r_run_d         <= 1'b0;
      r_idx_d         <= '0;
      r_res_reports   <= '0;
      r_res_count     <= '0;
      r_res_first_idx <= '1;
    end else begin
      // Report of the symbol run last cycle arrives now; idx_d is its pre-increment index.
      r_run_d <= w_pop && !w_flush;
      r_idx_d <= r_res_count;
      if (w_pop && (r_res_count != '1)) r_res_count <= r_res_count + 1'b1;
      if (r_run_d) begin
        r_res_reports <= r_res_reports | auto_report;
        if ((auto_report != '0) && (r_res_first_idx == '1)) r_res_first_idx <= r_idx_d;
      end

      // NOTE: later non-blocking assignments override earlier ones, so clears below take priority.
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state         <= ST_ARM;
            r_busy          <= 1'b1;
            r_res_reports   <= '0;
            r_res_count     <= '0;
            r_res_first_idx <= '1;
          end
        end
        ST_ARM: begin
          r_state      <= ST_STREAM;
          r_auto_reset <= 1'b0;
        end
        ST_STREAM: begin
          if (w_pop && w_head[8]) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          r_state     <= ST_DONE;
          r_res_valid <= 1'b1;
        end
        ST_DONE: begin
          if (res_ready) begin
            r_state      <= ST_IDLE;
            r_res_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_auto_reset <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_flush) begin
        r_state         <= ST_IDLE;
        r_auto_reset    <= 1'b1;
        r_res_valid     <= 1'b0;
        r_busy          <= 1'b0;
        r_res_reports   <= '0;
        r_res_count     <= '0;
        r_res_first_idx <= '1;
      end
    end
  end

endmodule
